regbank_arbiter: RTL

Two-port access controller for a bank of `NREG` 8-bit enabled registers. It arbitrates between requester A (the SPI slave front end) and requester B (local logic). Each access runs as a 4-phase req/ack transaction. For the granted access the block drives a one-hot write enable and the shared write data into the bank, and returns read data from the bank outputs. It sits between the SPI command decoder and the memory register bank.

---
 rtl/regbank_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/regbank_arbiter.sv
// Two-requester access controller for a bank of NREG 8-bit registers.
// Grants one 4-phase req/ack transaction at a time, alternating on contention.
module regbank_arbiter #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [7:0]        a_wdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [7:0]        b_wdata,
    output logic              b_ack,
    output logic [7:0]        rdata,
    output logic              err,
    output logic [NREG-1:0]   reg_wrenable,
    output logic [7:0]        reg_d,
    input  logic [NREG*8-1:0] reg_q,
    output logic [1:0]        state_dbg
);
    // Handshake: a requester raises req (a level) with we/addr/wdata stable and keeps
    // it high until it sees ack; ack, rdata and err then hold until req is sampled low.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t          state;
    logic            prio;
    logic            gnt_b;
    logic            l_we;
    logic [AW-1:0]   l_addr;
    logic [7:0]      l_wdata;

    logic            sel_b;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [7:0]      s_wdata;
    logic [NREG-1:0] s_wren;
    logic [7:0]      rd_sel;
    logic            l_oor;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREG);
    endfunction

    assign state_dbg = state;

    always_comb begin
        sel_b   = b_req && (!a_req || prio);
        s_we    = sel_b ? b_we    : a_we;
        s_addr  = sel_b ? b_addr  : a_addr;
        s_wdata = sel_b ? b_wdata : a_wdata;
        // Only in-range indices can match, so out-of-range writes enable nothing.
        s_wren  = '0;
        rd_sel  = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            if (s_we && s_addr == AW'(i)) s_wren[i] = 1'b1;
            if (l_addr == AW'(i))         rd_sel    = reg_q[i*8 +: 8];
        end
        l_oor = !in_range(l_addr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            prio         <= 1'b0;
            gnt_b        <= 1'b0;
            l_we         <= 1'b0;
            l_addr       <= '0;
            l_wdata      <= 8'h00;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            rdata        <= 8'h00;
            err          <= 1'b0;
            reg_wrenable <= '0;
            reg_d        <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        gnt_b        <= sel_b;
                        l_we         <= s_we;
                        l_addr       <= s_addr;
                        l_wdata      <= s_wdata;
                        reg_d        <= s_wdata;
                        reg_wrenable <= s_wren;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    reg_wrenable <= '0;
                    rdata        <= l_oor ? 8'h00 : (l_we ? l_wdata : rd_sel);
                    err          <= l_oor;
                    a_ack        <= !gnt_b;
                    b_ack        <= gnt_b;
                    prio         <= !gnt_b;
                    state        <= ACK;
                end
                ACK: begin
                    if (gnt_b ? !b_req : !a_req) begin
                        a_ack <= 1'b0;
                        b_ack <= 1'b0;
                        rdata <= 8'h00;
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
